// File: rtl/vga_timing_decoder_480p.sv
// Receive-side 480p timing decoder: recovers sx/sy from hsync/vsync/de,
// measures line/frame geometry and reports lock against the expected format.
`timescale 1ns/1ps

module vga_timing_decoder_480p #(
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic       clk_vga,
   input  logic       rst_n,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       de,
   output logic [9:0] sx,
   output logic [9:0] sy,
   output logic       de_out,
   output logic       frame_start,
   output logic [9:0] h_total_meas,
   output logic [9:0] h_active_meas,
   output logic [9:0] v_total_meas,
   output logic [9:0] v_active_meas,
   output logic       locked,
   output logic       err
);

   localparam int unsigned CW = 10;
   localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   logic          r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
   logic          w_hs_edge, w_vs_edge, w_de_rise, w_de_fall;
   logic [CW-1:0] r_sx, r_sy;
   logic          r_de_out, r_frame_start, r_frame_pend;
   logic [CW-1:0] r_hcnt, r_dcnt, r_vcnt, r_acnt, r_idle;
   logic [CW-1:0] w_vcnt_nxt, w_acnt_nxt;
   logic [CW-1:0] r_h_total, r_h_active, r_v_total, r_v_active;
   logic          r_eval, w_match, w_timeout;
   state_t        r_state, w_state_nxt;
   logic [GW-1:0] r_good, w_good_nxt;
   logic          r_locked, r_err, w_locked_nxt, w_err_nxt;

   // Input sampling; idle values so reset never fakes an edge
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         r_hs1 <= 1'b1;
         r_vs1 <= 1'b1;
         r_de1 <= 1'b0;
         r_hs2 <= 1'b1;
         r_vs2 <= 1'b1;
         r_de2 <= 1'b0;
      end else begin
         r_hs1 <= hsync;
         r_vs1 <= vsync;
         r_de1 <= de;
         r_hs2 <= r_hs1;
         r_vs2 <= r_vs1;
         r_de2 <= r_de1;
      end
   end

   assign w_hs_edge = r_hs2 & ~r_hs1;
   assign w_vs_edge = r_vs2 & ~r_vs1;
   assign w_de_rise = ~r_de2 & r_de1;
   assign w_de_fall = r_de2 & ~r_de1;
   assign w_timeout = (r_idle == CW'(TIMEOUT));

   // Coordinate recovery, aligned with de_out
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         r_sx          <= '0;
         r_sy          <= '0;
         r_de_out      <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_pend  <= 1'b0;
      end else begin
         r_de_out      <= r_de1;
         r_frame_start <= w_de_rise & r_frame_pend;
         if (w_de_rise) begin
            r_sx <= '0;
            r_sy <= r_frame_pend ? '0 : sat_inc(r_sy);
         end else if (r_de1) begin
            r_sx <= sat_inc(r_sx);
         end
         if (w_timeout)      r_frame_pend <= 1'b0;
         else if (w_vs_edge) r_frame_pend <= 1'b1;
         else if (w_de_rise) r_frame_pend <= 1'b0;
      end
   end

   // A same-cycle hs_edge/de_rise belongs to the frame being closed
   assign w_vcnt_nxt = w_hs_edge ? sat_inc(r_vcnt) : r_vcnt;
   assign w_acnt_nxt = w_de_rise ? sat_inc(r_acnt) : r_acnt;

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         r_hcnt     <= '0;
         r_dcnt     <= '0;
         r_vcnt     <= '0;
         r_acnt     <= '0;
         r_idle     <= '0;
         r_h_total  <= '0;
         r_h_active <= '0;
         r_v_total  <= '0;
         r_v_active <= '0;
         r_eval     <= 1'b0;
      end else begin
         r_eval <= w_vs_edge;
         if (w_hs_edge) begin
            r_h_total <= r_hcnt;
            r_hcnt    <= CW'(1);
            r_idle    <= '0;
         end else begin
            r_hcnt <= sat_inc(r_hcnt);
            if (!w_timeout) r_idle <= r_idle + CW'(1);
         end
         if (w_de_fall) begin
            r_h_active <= r_dcnt;
            r_dcnt     <= '0;
         end else if (r_de1) begin
            r_dcnt <= sat_inc(r_dcnt);
         end
         if (w_vs_edge) begin
            r_v_total  <= w_vcnt_nxt;
            r_v_active <= w_acnt_nxt;
            r_vcnt     <= '0;
            r_acnt     <= '0;
         end else begin
            r_vcnt <= w_vcnt_nxt;
            r_acnt <= w_acnt_nxt;
         end
      end
   end

   assign w_match = (r_h_total  == CW'(H_TOTAL))  && (r_h_active == CW'(H_ACTIVE)) &&
                    (r_v_total  == CW'(V_TOTAL))  && (r_v_active == CW'(V_ACTIVE));

   // Lock FSM: state register
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_SEARCH;
         r_good  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
      end
   end

   // Lock FSM: next state; the first evaluation after SEARCH is a partial frame
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      if (w_timeout) begin
         w_state_nxt = ST_SEARCH;
         w_good_nxt  = '0;
      end else if (r_eval) begin
         case (r_state)
            ST_SEARCH: begin
               w_state_nxt = ST_MEASURE;
               w_good_nxt  = '0;
            end
            ST_MEASURE: begin
               if (!w_match) begin
                  w_good_nxt = '0;
               end else if (r_good == GW'(LOCK_FRAMES - 1)) begin
                  w_state_nxt = ST_LOCKED;
                  w_good_nxt  = GW'(LOCK_FRAMES);
               end else begin
                  w_good_nxt = r_good + GW'(1);
               end
            end
            ST_LOCKED: begin
               if (!w_match) begin
                  w_state_nxt = ST_MEASURE;
                  w_good_nxt  = '0;
               end
            end
            default: begin
               w_state_nxt = ST_SEARCH;
               w_good_nxt  = '0;
            end
         endcase
      end
   end

   // Lock FSM: outputs; any exit from LOCKED is an error
   always_comb begin
      w_locked_nxt = 1'b0;
      w_err_nxt    = 1'b0;
      w_locked_nxt = (w_state_nxt == ST_LOCKED);
      w_err_nxt    = (r_state == ST_LOCKED) && (w_state_nxt != ST_LOCKED);
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_locked <= w_locked_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign sx            = r_sx;
   assign sy            = r_sy;
   assign de_out        = r_de_out;
   assign frame_start   = r_frame_start;
   assign h_total_meas  = r_h_total;
   assign h_active_meas = r_h_active;
   assign v_total_meas  = r_v_total;
   assign v_active_meas = r_v_active;
   assign locked        = r_locked;
   assign err           = r_err;

endmodule

// File: tb/tb_vga_timing_decoder_480p.sv
// Bench for vga_timing_decoder_480p on a reduced 40x12 raster: scenario table,
// corner-case sequences and randomized streams against a cycle-level reference model.
`timescale 1ns/1ps

module tb_vga_timing_decoder_480p;

   localparam int HT = 40, HA = 32, VT = 12, VA = 8, LF = 2, TO = 100;

   logic       clk_vga = 1'b0, rst_n = 1'b0;
   logic       hsync = 1'b1, vsync = 1'b1, de = 1'b0;
   logic [9:0] sx, sy, h_total_meas, h_active_meas, v_total_meas, v_active_meas;
   logic       de_out, frame_start, locked, err;

   always #5 clk_vga = ~clk_vga;

   vga_timing_decoder_480p #(
      .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
      .LOCK_FRAMES(LF), .TIMEOUT(TO)
   ) dut (
      .clk_vga(clk_vga), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de),
      .sx(sx), .sy(sy), .de_out(de_out), .frame_start(frame_start),
      .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
      .v_total_meas(v_total_meas), .v_active_meas(v_active_meas),
      .locked(locked), .err(err)
   );

   int checks = 0, failures = 0;
   int err_cnt = 0, fs_cnt = 0, lst_sx = 0, lst_sy = 0, rst_hold = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: event counts kept as plain integers, clamped when reported
   bit m_pa_hs, m_pa_vs, m_pa_de, m_pb_hs, m_pb_vs, m_pb_de;
   int m_sx, m_sy, m_deo, m_fs, m_htot, m_hact, m_vtot, m_vact, m_locked, m_err;
   int m_hcnt, m_dcnt, m_lines, m_acts, m_idle, m_pend, m_eval_due, m_mode, m_good;

   function automatic int clamp(input int v);
      return (v > 1023) ? 1023 : v;
   endfunction

   task automatic model_reset();
      m_pa_hs = 1; m_pa_vs = 1; m_pa_de = 0; m_pb_hs = 1; m_pb_vs = 1; m_pb_de = 0;
      m_sx = 0; m_sy = 0; m_deo = 0; m_fs = 0; m_htot = 0; m_hact = 0; m_vtot = 0;
      m_vact = 0; m_locked = 0; m_err = 0; m_hcnt = 0; m_dcnt = 0; m_lines = 0;
      m_acts = 0; m_idle = 0; m_pend = 0; m_eval_due = 0; m_mode = 0; m_good = 0;
   endtask

   // Advance one clock; the pins seen two clocks ago and one clock ago form the edges
   task automatic model_step(input bit n_hs, input bit n_vs, input bit n_de);
      bit hs_e, vs_e, de_r, de_f, tout, ev, match;
      hs_e  = m_pa_hs && !m_pb_hs;
      vs_e  = m_pa_vs && !m_pb_vs;
      de_r  = !m_pa_de && m_pb_de;
      de_f  = m_pa_de && !m_pb_de;
      tout  = (m_idle >= TO);
      ev    = (m_eval_due != 0);
      match = (m_htot == HT) && (m_hact == HA) && (m_vtot == VT) && (m_vact == VA);
      m_deo = int'(m_pb_de);
      m_fs  = (de_r && m_pend != 0) ? 1 : 0;
      if (de_r) begin
         m_sx = 0;
         m_sy = (m_pend != 0) ? 0 : clamp(m_sy + 1);
      end else if (m_pb_de) m_sx = clamp(m_sx + 1);
      if (tout) m_pend = 0;
      else if (vs_e) m_pend = 1;
      else if (de_r) m_pend = 0;
      if (hs_e) begin m_htot = clamp(m_hcnt); m_hcnt = 1; end
      else m_hcnt++;
      if (de_f) begin m_hact = clamp(m_dcnt); m_dcnt = 0; end
      else if (m_pb_de) m_dcnt++;
      m_lines += int'(hs_e);
      m_acts  += int'(de_r);
      if (vs_e) begin
         m_vtot = clamp(m_lines); m_vact = clamp(m_acts); m_lines = 0; m_acts = 0;
      end
      m_idle     = hs_e ? 0 : m_idle + 1;
      m_eval_due = int'(vs_e);
      m_err = 0;
      if (tout) begin
         if (m_mode == 2) m_err = 1;
         m_mode = 0; m_good = 0;
      end else if (ev) begin
         if (m_mode == 0) begin
            m_mode = 1; m_good = 0;
         end else if (m_mode == 1) begin
            m_good = match ? m_good + 1 : 0;
            if (m_good == LF) m_mode = 2;
         end else if (!match) begin
            m_err = 1; m_mode = 1; m_good = 0;
         end
      end
      m_locked = (m_mode == 2) ? 1 : 0;
      m_pa_hs = m_pb_hs; m_pa_vs = m_pb_vs; m_pa_de = m_pb_de;
      m_pb_hs = n_hs;    m_pb_vs = n_vs;    m_pb_de = n_de;
   endtask

   task automatic compare_all();
      check("sx", int'(sx), m_sx);
      check("sy", int'(sy), m_sy);
      check("de_out", int'(de_out), m_deo);
      check("frame_start", int'(frame_start), m_fs);
      check("h_total_meas", int'(h_total_meas), m_htot);
      check("h_active_meas", int'(h_active_meas), m_hact);
      check("v_total_meas", int'(v_total_meas), m_vtot);
      check("v_active_meas", int'(v_active_meas), m_vact);
      check("locked", int'(locked), m_locked);
      check("err", int'(err), m_err);
   endtask

   // One pixel clock: drive at negedge, model at posedge, compare at next negedge
   task automatic drive(input bit p_hs, input bit p_vs, input bit p_de);
      hsync = p_hs; vsync = p_vs; de = p_de;
      @(posedge clk_vga);
      if (!rst_n) model_reset();
      else model_step(p_hs, p_vs, p_de);
      @(negedge clk_vga);
      compare_all();
      if (de_out) begin lst_sx = int'(sx); lst_sy = int'(sy); end
      if (frame_start) begin
         fs_cnt++;
         check("fs_align", {int'(de_out), int'(sx), int'(sy)} == {1, 0, 0} ? 1 : 0, 1);
      end
      if (err) err_cnt++;
      if (rst_hold > 0) begin
         rst_hold--;
         if (rst_hold == 0) rst_n = 1'b1;
      end
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_sx", int'(sx), 0);
      check("rst_async_de_out", int'(de_out), 0);
      check("rst_async_h_total", int'(h_total_meas), 0);
      check("rst_async_v_total", int'(v_total_meas), 0);
      check("rst_async_locked", int'(locked), 0);
      model_reset();
      rst_hold = 3;
   endtask

   // vsync occupies the last two lines; hsync is 4 clocks starting 2 after active
   task automatic send_frame(input int ht, input int ha, input int vt, input int va,
                             input int rst_at);
      for (int l = 0; l < vt; l++)
         for (int x = 0; x < ht; x++) begin
            if (l * ht + x == rst_at) apply_reset();
            drive(!(x >= ha + 2 && x < ha + 6), !(l >= vt - 2), (l < va) && (x < ha));
         end
   endtask

   typedef struct {
      int ht, ha, vt, va;
      int e_htot, e_hact, e_vtot, e_vact, e_locked, e_errs;
   } row_t;
   row_t tbl[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{HT, HA, VT, VA,     HT, HA, 10, VA, 0, 0};
      tbl[1]  = '{HT, HA, VT, VA,     HT, HA, VT, VA, 0, 0};
      tbl[2]  = '{HT, HA, VT, VA,     HT, HA, VT, VA, 1, 0};
      tbl[3]  = '{HT+1, HA, VT, VA,   HT+1, HA, VT, VA, 0, 1};
      tbl[4]  = '{HT, HA, VT, VA,     HT, HA, VT, VA, 0, 0};
      tbl[5]  = '{HT, HA, VT, VA,     HT, HA, VT, VA, 1, 0};
      tbl[6]  = '{HT, HA, VT, VA-1,   HT, HA, VT, VA-1, 0, 1};
      tbl[7]  = '{HT, HA, VT, VA-1,   HT, HA, VT, VA-1, 0, 0};
      tbl[8]  = '{HT, HA, VT+1, VA,   HT, HA, VT+1, VA, 0, 0};
      tbl[9]  = '{HT, HA, VT, VA,     HT, HA, VT, VA, 0, 0};
      tbl[10] = '{HT, HA, VT, VA,     HT, HA, VT, VA, 1, 0};

      model_reset();
      repeat (3) @(negedge clk_vga);
      compare_all();
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         err_cnt = 0;
         send_frame(tbl[i].ht, tbl[i].ha, tbl[i].vt, tbl[i].va, -1);
         check($sformatf("row%0d_h_total", i), int'(h_total_meas), tbl[i].e_htot);
         check($sformatf("row%0d_h_active", i), int'(h_active_meas), tbl[i].e_hact);
         check($sformatf("row%0d_v_total", i), int'(v_total_meas), tbl[i].e_vtot);
         check($sformatf("row%0d_v_active", i), int'(v_active_meas), tbl[i].e_vact);
         check($sformatf("row%0d_locked", i), int'(locked), tbl[i].e_locked);
         check($sformatf("row%0d_err_pulses", i), err_cnt, tbl[i].e_errs);
      end

      // Alignment on a locked stream
      for (int f = 0; f < 2; f++) begin
         fs_cnt = 0;
         send_frame(HT, HA, VT, VA, -1);
         check("fs_per_frame", fs_cnt, 1);
         check("last_pixel_sx", lst_sx, HA - 1);
         check("last_pixel_sy", lst_sy, VA - 1);
      end

      // Loss of signal while locked
      err_cnt = 0;
      repeat (150) drive(1'b1, 1'b1, 1'b0);
      check("timeout_locked", int'(locked), 0);
      check("timeout_err_pulses", err_cnt, 1);
      send_frame(HT, HA, VT, VA, -1);
      send_frame(HT, HA, VT, VA, -1);
      check("relock_after_2", int'(locked), 0);
      send_frame(HT, HA, VT, VA, -1);
      check("relock_after_3", int'(locked), 1);
      check("relock_err_pulses", err_cnt, 1);

      // Asynchronous reset mid-line
      send_frame(HT, HA, VT, VA, 3 * HT + 10);
      check("post_reset_partial", int'(locked), 0);
      send_frame(HT, HA, VT, VA, -1);
      check("post_reset_1", int'(locked), 0);
      send_frame(HT, HA, VT, VA, -1);
      check("post_reset_2", int'(locked), 1);

      // Saturation of column and de-high counters
      for (int i = 0; i < 1100; i++) drive(!(i % 50 == 49), 1'b1, 1'b1);
      check("sx_saturated", int'(sx), 1023);
      repeat (3) drive(1'b1, 1'b1, 1'b0);
      check("h_active_saturated", int'(h_active_meas), 1023);

      // Randomized geometry and pin noise
      for (int f = 0; f < 6; f++) begin
         int ht, ha, vt, va;
         ht = int'($urandom_range(38, 42));
         ha = int'($urandom_range(28, ht - 6));
         vt = int'($urandom_range(11, 14));
         va = int'($urandom_range(6, vt - 4));
         send_frame(ht, ha, vt, va, -1);
      end
      for (int i = 0; i < 300; i++)
         drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      repeat (120) drive(1'b1, 1'b1, 1'b0);
      for (int f = 0; f < 3; f++) send_frame(HT, HA, VT, VA, -1);
      check("relock_after_noise", int'(locked), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
